// File: rtl/bbox_msg_pkg.sv
// Shared constants, FSM state encoding and box payload type for the bounding-box message reader.
package bbox_msg_pkg;

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned ADDR_W  = 3;
  localparam int unsigned COORD_W = 11;
  localparam int unsigned USEDW_W = 8;
  localparam int unsigned CNT_W   = 8;

  localparam logic [ADDR_W-1:0] ADDR_STATUS    = 3'd0;
  localparam logic [ADDR_W-1:0] ADDR_MSG       = 3'd1;
  localparam logic [DATA_W-1:0] FLUSH_BIT      = 32'h0000_0010;
  localparam logic [DATA_W-1:0] MSG_ID_DEFAULT = 32'h0052_4242;

  // Field positions inside the status word and the two coordinate words
  localparam int unsigned USEDW_LSB = 8;
  localparam int unsigned RED_BIT   = 31;
  localparam int unsigned X_LSB     = 16;
  localparam int unsigned Y_LSB     = 0;

  localparam logic [USEDW_W-1:0] MSG_WORDS = 8'd3;

  typedef enum logic [3:0] {
    S_WAIT,
    S_ST_RD,
    S_ST_WT,
    S_ID_RD,
    S_ID_WT,
    S_W1_RD,
    S_W1_WT,
    S_W2_RD,
    S_W2_WT,
    S_OUT,
    S_ERR,
    S_ERR_IDLE
  } state_t;

  typedef struct packed {
    logic               red;
    logic [COORD_W-1:0] left;
    logic [COORD_W-1:0] top;
    logic [COORD_W-1:0] right;
    logic [COORD_W-1:0] bottom;
  } box_t;

  function automatic logic [COORD_W-1:0] get_x(input logic [DATA_W-1:0] d);
    return d[X_LSB +: COORD_W];
  endfunction

  function automatic logic [COORD_W-1:0] get_y(input logic [DATA_W-1:0] d);
    return d[Y_LSB +: COORD_W];
  endfunction

endpackage

// File: rtl/bbox_msg_reader.sv
// Avalon-MM master draining the image processor's "RBB" box-message FIFO into a valid/ready box stream.
// Optional BBOX_FLUSH_ON_ERR_EN: on an ID mismatch, flush the slave FIFO instead of word-by-word resync.
module bbox_msg_reader
  import bbox_msg_pkg::*;
#(
  parameter int unsigned        POLL_INTERVAL = 1024,
  parameter int unsigned        READ_LATENCY  = 1,
  parameter logic [DATA_W-1:0]  MSG_ID        = MSG_ID_DEFAULT
) (
  input  logic                clk,
  input  logic                reset_n,
  output logic                m_chipselect,
  output logic                m_read,
  output logic                m_write,
  output logic [ADDR_W-1:0]   m_address,
  output logic [DATA_W-1:0]   m_writedata,
  input  logic [DATA_W-1:0]   m_readdata,
  output logic                box_valid,
  input  logic                box_ready,
  output logic [COORD_W-1:0]  box_left,
  output logic [COORD_W-1:0]  box_top,
  output logic [COORD_W-1:0]  box_right,
  output logic [COORD_W-1:0]  box_bottom,
  output logic                box_red,
  output logic                box_empty,
  output logic [CNT_W-1:0]    sync_err_cnt
);

  localparam int unsigned TMR_W = (POLL_INTERVAL > 2) ? $clog2(POLL_INTERVAL) : 1;
  localparam int unsigned LAT_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [TMR_W-1:0]     r_timer;
  logic [LAT_W-1:0]     r_lat;
  logic                 r_resync;
  logic [CNT_W-1:0]     r_err_cnt;
  box_t                 r_shadow;
  box_t                 r_box;
  logic                 r_box_valid;
  logic                 r_m_read;
  logic                 r_m_write;
  logic [ADDR_W-1:0]    r_m_address;
  logic [DATA_W-1:0]    r_m_writedata;

  logic                 w_is_wt;
  logic                 w_sample;
  logic [USEDW_W-1:0]   w_usedw;
  logic                 w_tmr_reload;
  logic                 w_err_inc;
  logic                 w_resync_set;
  logic                 w_resync_clr;
  logic                 w_ld_w1;
  logic                 w_ld_w2;
  logic                 w_out_load;
  logic                 w_rd_nxt;
  logic                 w_wr_nxt;
  logic [ADDR_W-1:0]    w_addr_nxt;
  logic [DATA_W-1:0]    w_wdata_nxt;

  // readdata is valid READ_LATENCY cycles after the pulse; the wait states count up to it
  assign w_is_wt  = r_state inside {S_ST_WT, S_ID_WT, S_W1_WT, S_W2_WT};
  assign w_sample = w_is_wt && (r_lat == LAT_W'(READ_LATENCY - 1));
  assign w_usedw  = m_readdata[USEDW_LSB +: USEDW_W];

  always_ff @(posedge clk) begin
    if (!reset_n) r_state <= S_WAIT;
    else          r_state <= w_state_nxt;
  end

  // Next state plus the bus pulse for the state being entered, so pulses come straight from flops
  always_comb begin
    w_state_nxt  = r_state;
    w_tmr_reload = 1'b0;
    w_err_inc    = 1'b0;
    w_resync_set = 1'b0;
    w_resync_clr = 1'b0;
    w_ld_w1      = 1'b0;
    w_ld_w2      = 1'b0;
    w_out_load   = 1'b0;
    w_rd_nxt     = 1'b0;
    w_wr_nxt     = 1'b0;
    w_addr_nxt   = ADDR_STATUS;
    w_wdata_nxt  = '0;

    case (r_state)
      S_WAIT: begin
        if (r_timer == '0) begin
          w_state_nxt  = S_ST_RD;
          w_tmr_reload = 1'b1;
        end
      end
      S_ST_RD: w_state_nxt = S_ST_WT;
      S_ST_WT: begin
        if (w_sample) begin
          if (w_usedw >= MSG_WORDS)                 w_state_nxt = S_ID_RD;
          else if ((w_usedw != '0) && r_resync)     w_state_nxt = S_ID_RD;
          else                                      w_state_nxt = S_WAIT;
        end
      end
      S_ID_RD: w_state_nxt = S_ID_WT;
      S_ID_WT: begin
        if (w_sample) begin
          if (m_readdata == MSG_ID) begin
            w_resync_clr = 1'b1;
            w_state_nxt  = S_W1_RD;
          end else begin
            w_err_inc    = 1'b1;
            w_resync_set = 1'b1;
            w_state_nxt  = S_ERR;
          end
        end
      end
      S_W1_RD: w_state_nxt = S_W1_WT;
      S_W1_WT: begin
        if (w_sample) begin
          w_ld_w1     = 1'b1;
          w_state_nxt = S_W2_RD;
        end
      end
      S_W2_RD: w_state_nxt = S_W2_WT;
      S_W2_WT: begin
        if (w_sample) begin
          w_ld_w2     = 1'b1;
          w_state_nxt = S_OUT;
        end
      end
      S_OUT: begin
        // Hold here until the output register is free or being accepted this cycle
        if (!r_box_valid || box_ready) begin
          w_out_load  = 1'b1;
          w_state_nxt = S_ST_RD;
        end
      end
`ifdef BBOX_FLUSH_ON_ERR_EN
      S_ERR:      w_state_nxt = S_ERR_IDLE;
`else
      S_ERR:      w_state_nxt = S_ST_RD;
`endif
      S_ERR_IDLE: begin
        // FIFO was just flushed, so nothing stale is left to skip
        w_state_nxt  = S_WAIT;
        w_tmr_reload = 1'b1;
        w_resync_clr = 1'b1;
      end
      default: w_state_nxt = S_WAIT;
    endcase

    w_rd_nxt = w_state_nxt inside {S_ST_RD, S_ID_RD, S_W1_RD, S_W2_RD};
    if (w_rd_nxt && (w_state_nxt != S_ST_RD)) w_addr_nxt = ADDR_MSG;
`ifdef BBOX_FLUSH_ON_ERR_EN
    if (w_state_nxt == S_ERR) begin
      w_wr_nxt    = 1'b1;
      w_wdata_nxt = FLUSH_BIT;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_m_read      <= 1'b0;
      r_m_write     <= 1'b0;
      r_m_address   <= '0;
      r_m_writedata <= '0;
    end else begin
      r_m_read      <= w_rd_nxt;
      r_m_write     <= w_wr_nxt;
      r_m_address   <= w_addr_nxt;
      r_m_writedata <= w_wdata_nxt;
    end
  end

  // Free-running poll timer, reloaded when a poll is launched or after a flush
  always_ff @(posedge clk) begin
    if (!reset_n)           r_timer <= '0;
    else if (w_tmr_reload)  r_timer <= TMR_W'(POLL_INTERVAL - 1);
    else if (r_timer != '0) r_timer <= r_timer - TMR_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!reset_n)                r_lat <= '0;
    else if (w_is_wt && !w_sample) r_lat <= r_lat + LAT_W'(1);
    else                         r_lat <= '0;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_resync  <= 1'b0;
      r_err_cnt <= '0;
    end else begin
      if (w_resync_set)      r_resync <= 1'b1;
      else if (w_resync_clr) r_resync <= 1'b0;
      if (w_err_inc && (r_err_cnt != '1)) r_err_cnt <= r_err_cnt + CNT_W'(1);
    end
  end

  // Shadow collects the two coordinate words; reserved bits are dropped here
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_shadow <= '0;
    end else if (w_ld_w1) begin
      r_shadow.red  <= m_readdata[RED_BIT];
      r_shadow.left <= get_x(m_readdata);
      r_shadow.top  <= get_y(m_readdata);
    end else if (w_ld_w2) begin
      r_shadow.right  <= get_x(m_readdata);
      r_shadow.bottom <= get_y(m_readdata);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_box       <= '0;
      r_box_valid <= 1'b0;
    end else if (w_out_load) begin
      r_box       <= r_shadow;
      r_box_valid <= 1'b1;
    end else if (box_ready) begin
      r_box_valid <= 1'b0;
    end
  end

  assign m_chipselect = r_m_read | r_m_write;
  assign m_read       = r_m_read;
  assign m_write      = r_m_write;
  assign m_address    = r_m_address;
  assign m_writedata  = r_m_writedata;

  assign box_valid    = r_box_valid;
  assign box_left     = r_box.left;
  assign box_top      = r_box.top;
  assign box_right    = r_box.right;
  assign box_bottom   = r_box.bottom;
  assign box_red      = r_box.red;
  assign box_empty    = (r_box.left > r_box.right) || (r_box.top > r_box.bottom);
  assign sync_err_cnt = r_err_cnt;

endmodule
